// File: rtl/crtg_pkg.sv
// Shared types and constants for the CRTG sequencer: FSM states, LFSR
// polynomial and word width, and the initial detection-threshold divisor.
package crtg_pkg;

    typedef enum logic [3:0] {
        IDLE   = 4'd0,
        CHECK  = 4'd1,
        GEN    = 4'd2,
        INJECT = 4'd3,
        CMP    = 4'd4,
        NEXT   = 4'd5,
        DECIDE = 4'd6,
        MERGE  = 4'd7,
        COVUPD = 4'd8,
        EMIT   = 4'd9,
        DONE   = 4'd10
    } state_t;

    localparam logic [31:0] LFSR_POLY  = 32'h8020_0003;
    localparam int          LFSR_W     = 32;
    localparam int          THRESH_DIV = 20;

    // Number of LFSR words needed to fill a vector of the given width.
    function automatic int words_for(input int width);
        return (width + LFSR_W - 1) / LFSR_W;
    endfunction

endpackage

// File: rtl/crtg_lfsr.sv
// 32-bit Galois LFSR (right-shifting form). A zero seed is replaced by 1 so
// the register can never lock up in the all-zero state.
module crtg_lfsr
    import crtg_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic [LFSR_W-1:0] seed,
    input  logic              advance,
    output logic [LFSR_W-1:0] next_value
);

    logic [LFSR_W-1:0] state_r;

    // Next LFSR value from the current state.
    always_comb begin
        if (state_r[0]) begin
            next_value = {1'b0, state_r[LFSR_W-1:1]} ^ LFSR_POLY;
        end else begin
            next_value = {1'b0, state_r[LFSR_W-1:1]};
        end
    end

    // LFSR state register: seed load has priority over advancing.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= 32'd1;
        end else if (load) begin
            state_r <= (seed == 32'd0) ? 32'd1 : seed;
        end else if (advance) begin
            state_r <= next_value;
        end else begin
            state_r <= state_r;
        end
    end

endmodule

// File: rtl/crtg_sequencer.sv
// Coverage-driven random test generation controller. Optional build macro
// CRTG_FAULT_DROP_EN skips already-detected faults instead of re-injecting them.
module crtg_sequencer
    import crtg_pkg::*;
#(
    parameter int NUM_FAULTS  = 1798,
    parameter int FIDX_W      = 11,
    parameter int VEC_W       = 157,
    parameter int OUT_W       = 64,
    parameter int UT_LIMIT    = 20,
    parameter int DESIRED_COV = 90,
    parameter int STEP        = 10,
    parameter int SETTLE      = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [31:0]       seed,
    output logic [VEC_W-1:0]  test_vec,
    output logic [FIDX_W-1:0] fault_idx,
    output logic              fault_en,
    input  logic [OUT_W-1:0]  good_out,
    input  logic [OUT_W-1:0]  faulty_out,
    output logic              keep_valid,
    input  logic              keep_ready,
    output logic              busy,
    output logic              done,
    output logic [6:0]        coverage,
    output logic [15:0]       kept_cnt,
    output logic [15:0]       total_cnt
);

    localparam int                MAP_W     = 1 << FIDX_W;
    localparam int                NW        = words_for(VEC_W);
    localparam logic [7:0]        GEN_LAST  = 8'(NW - 1);
    localparam logic [7:0]        SET_LAST  = 8'(SETTLE - 1);
    localparam logic [FIDX_W-1:0] FIRST_IDX = FIDX_W'(1);
    localparam logic [FIDX_W-1:0] LAST_IDX  = FIDX_W'(NUM_FAULTS);

    state_t            state_r, state_s;
    logic [MAP_W-1:0]  at_map_r, ct_map_r;
    logic [FIDX_W-1:0] exp_cnt_r, det_at_r, new_cnt_r, idx_inc_s;
    logic [7:0]        u_tests_r, cov_edge_r, gen_cnt_r, settle_cnt_r;
    logic [31:0]       det_scaled_s, cov_thr_s, lfsr_next_s;
    logic              cov_step_s, lfsr_load_s, lfsr_adv_s;

    crtg_lfsr u_lfsr (
        .clk        (clk),
        .rst        (rst),
        .load       (lfsr_load_s),
        .seed       (seed),
        .advance    (lfsr_adv_s),
        .next_value (lfsr_next_s)
    );

    // Datapath helpers: LFSR control, index increment, coverage-step test.
    always_comb begin
        lfsr_load_s  = (state_r == IDLE) && start;
        lfsr_adv_s   = (state_r == GEN);
        idx_inc_s    = fault_idx + FIDX_W'(1);
        det_scaled_s = 32'(det_at_r) * 32'd100;
        cov_thr_s    = (32'(coverage) + 32'd1) * 32'(NUM_FAULTS);
        cov_step_s   = (det_scaled_s >= cov_thr_s);
    end

    // Next-state logic.
    always_comb begin
        state_s = state_r;
        case (state_r)
            IDLE: begin
                if (start) state_s = CHECK;
                else       state_s = IDLE;
            end
            CHECK: begin
                if (coverage >= 7'(DESIRED_COV) || u_tests_r >= 8'(UT_LIMIT)) state_s = DONE;
                else                                                          state_s = GEN;
            end
            GEN: begin
                if (gen_cnt_r == GEN_LAST) begin
`ifdef CRTG_FAULT_DROP_EN
                    state_s = at_map_r[FIRST_IDX] ? NEXT : INJECT;
`else
                    state_s = INJECT;
`endif
                end else begin
                    state_s = GEN;
                end
            end
            INJECT: begin
                if (settle_cnt_r == SET_LAST) state_s = CMP;
                else                          state_s = INJECT;
            end
            CMP: state_s = NEXT;
            NEXT: begin
                if (fault_idx == LAST_IDX) begin
                    state_s = DECIDE;
                end else begin
`ifdef CRTG_FAULT_DROP_EN
                    // A detected successor is walked over here, one cycle each.
                    state_s = at_map_r[idx_inc_s] ? NEXT : INJECT;
`else
                    state_s = INJECT;
`endif
                end
            end
            DECIDE: begin
                if (new_cnt_r >= exp_cnt_r && new_cnt_r != FIDX_W'(0)) state_s = MERGE;
                else                                                    state_s = CHECK;
            end
            MERGE: state_s = COVUPD;
            COVUPD: begin
                if (cov_step_s) state_s = COVUPD;
                else            state_s = EMIT;
            end
            EMIT: begin
                if (keep_valid && keep_ready) state_s = CHECK;
                else                          state_s = EMIT;
            end
            DONE:    state_s = IDLE;
            default: state_s = IDLE;
        endcase
    end

    // State, registered outputs, counters and bitmaps.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r      <= IDLE;
            test_vec     <= '0;
            fault_idx    <= '0;
            fault_en     <= 1'b0;
            keep_valid   <= 1'b0;
            busy         <= 1'b0;
            done         <= 1'b0;
            coverage     <= 7'd0;
            kept_cnt     <= 16'd0;
            total_cnt    <= 16'd0;
            at_map_r     <= '0;
            ct_map_r     <= '0;
            exp_cnt_r    <= '0;
            det_at_r     <= '0;
            new_cnt_r    <= '0;
            u_tests_r    <= 8'd0;
            cov_edge_r   <= 8'd0;
            gen_cnt_r    <= 8'd0;
            settle_cnt_r <= 8'd0;
        end else begin
            state_r    <= state_s;
            fault_en   <= (state_s == INJECT) || (state_s == CMP);
            keep_valid <= (state_s == EMIT);
            busy       <= (state_s != IDLE) && (state_s != DONE);
            case (state_r)
                IDLE: begin
                    if (start) begin
                        done       <= 1'b0;
                        exp_cnt_r  <= FIDX_W'(NUM_FAULTS / THRESH_DIV);
                        cov_edge_r <= 8'(STEP);
                        u_tests_r  <= 8'd0;
                        det_at_r   <= '0;
                        at_map_r   <= '0;
                        ct_map_r   <= '0;
                        coverage   <= 7'd0;
                        kept_cnt   <= 16'd0;
                        total_cnt  <= 16'd0;
                        gen_cnt_r  <= 8'd0;
                    end
                end
                GEN: begin
                    test_vec <= VEC_W'({test_vec, lfsr_next_s});
                    if (gen_cnt_r == GEN_LAST) begin
                        gen_cnt_r    <= 8'd0;
                        settle_cnt_r <= 8'd0;
                        fault_idx    <= FIRST_IDX;
                        new_cnt_r    <= '0;
                        ct_map_r     <= '0;
                        if (total_cnt != 16'hFFFF) total_cnt <= total_cnt + 16'd1;
                        if (u_tests_r != 8'hFF)    u_tests_r <= u_tests_r + 8'd1;
                    end else begin
                        gen_cnt_r <= gen_cnt_r + 8'd1;
                    end
                end
                INJECT: begin
                    if (settle_cnt_r == SET_LAST) settle_cnt_r <= 8'd0;
                    else                          settle_cnt_r <= settle_cnt_r + 8'd1;
                end
                CMP: begin
                    if (good_out != faulty_out) begin
                        ct_map_r[fault_idx] <= 1'b1;
                        if (!at_map_r[fault_idx]) new_cnt_r <= new_cnt_r + FIDX_W'(1);
                    end
                end
                NEXT: begin
                    if (fault_idx != LAST_IDX) fault_idx <= idx_inc_s;
                end
                MERGE: begin
                    at_map_r  <= at_map_r | ct_map_r;
                    det_at_r  <= det_at_r + new_cnt_r;
                    u_tests_r <= 8'd0;
                    if (kept_cnt != 16'hFFFF) kept_cnt <= kept_cnt + 16'd1;
                end
                COVUPD: begin
                    // Threshold relaxes at most once per kept vector.
                    if (cov_step_s) begin
                        coverage <= coverage + 7'd1;
                    end else if ({1'b0, coverage} >= cov_edge_r) begin
                        cov_edge_r <= cov_edge_r + 8'(STEP);
                        exp_cnt_r  <= exp_cnt_r >> 1;
                    end
                end
                DONE: done <= 1'b1;
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_crtg_sequencer.sv
// Directed self-checking bench for crtg_sequencer with a 40-fault stub CUT;
// expectations adjust when built with CRTG_FAULT_DROP_EN.
module tb_crtg_sequencer;

    localparam int NF    = 40;
    localparam int FW    = 6;
    localparam int VW    = 157;
    localparam int OW    = 64;

`ifdef CRTG_FAULT_DROP_EN
    localparam int EXP_EN_CYC = 2280;
    localparam int EXP_LATE   = 0;
`else
    localparam int EXP_EN_CYC = 2520;
    localparam int EXP_LATE   = 240;
`endif

    logic          clk = 1'b0;
    logic          rst, start, keep_ready;
    logic [31:0]   seed;
    logic [VW-1:0] test_vec;
    logic [FW-1:0] fault_idx;
    logic          fault_en, keep_valid, busy, done;
    logic [OW-1:0] good_out, faulty_out;
    logic [6:0]    coverage;
    logic [15:0]   kept_cnt, total_cnt;

    int n_checks = 0;
    int n_errors = 0;
    int mode     = 0;
    int en_cyc   = 0;
    int late_inj = 0;
    int kv_cyc   = 0;

    crtg_sequencer #(
        .NUM_FAULTS(NF), .FIDX_W(FW), .VEC_W(VW), .OUT_W(OW),
        .UT_LIMIT(20), .DESIRED_COV(90), .STEP(10), .SETTLE(2)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .seed(seed),
        .test_vec(test_vec), .fault_idx(fault_idx), .fault_en(fault_en),
        .good_out(good_out), .faulty_out(faulty_out),
        .keep_valid(keep_valid), .keep_ready(keep_ready),
        .busy(busy), .done(done), .coverage(coverage),
        .kept_cnt(kept_cnt), .total_cnt(total_cnt)
    );

    always #5 clk = ~clk;

    // Stub CUT pair: mode 1 detects every fault, mode 2 only faults 1..4.
    always_comb begin
        good_out   = 64'hA5A5_0F0F_1234_5678;
        faulty_out = good_out;
        if (fault_en && ((mode == 1) || (mode == 2 && fault_idx >= 6'd1 && fault_idx <= 6'd4)))
            faulty_out = good_out ^ 64'h0000_0000_0000_0001;
    end

    always @(negedge clk) begin
        if (fault_en) en_cyc++;
        if (keep_valid) kv_cyc++;
        if (fault_en && kept_cnt != 16'd0 && fault_idx >= 6'd1 && fault_idx <= 6'd4) late_inj++;
    end

    function automatic logic [31:0] lfsr_nx(input logic [31:0] s);
        return {1'b0, s[31:1]} ^ (s[0] ? 32'h8020_0003 : 32'h0);
    endfunction

    task automatic model_vec(input logic [31:0] st_in, output logic [31:0] st_out,
                             output logic [VW-1:0] v);
        logic [31:0]  st;
        logic [159:0] acc;
        st  = (st_in == 32'd0) ? 32'd1 : st_in;
        acc = '0;
        for (int w = 0; w < 5; w++) begin
            st  = lfsr_nx(st);
            acc = {acc[127:0], st};
        end
        v      = acc[VW-1:0];
        st_out = st;
    endtask

    task automatic chk(input string tag, input logic [159:0] obs, input logic [159:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    logic [VW-1:0] mv, mv2, cap, vec_a;
    logic [31:0]   mst, mst2;
    int            base_en, base_late, base_kv, bad;

    initial begin
        rst = 1'b1; start = 1'b0; seed = 32'd0; keep_ready = 1'b1;
        tick(); tick();
        chk("rst_fault_en", fault_en, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_keep_valid", keep_valid, 0);
        chk("rst_counters", {coverage, kept_cnt, total_cnt, fault_idx}, 0);
        chk("rst_test_vec", test_vec, 0);
        rst = 1'b0;
        tick();

        // Scenario 1: no detections, zero seed replaced by 1.
        mode = 0; base_kv = kv_cyc;
        seed = 32'd0; start = 1'b1; tick(); start = 1'b0;
        chk("s1_busy", busy, 1);
        for (int i = 0; i < 50 && fault_en !== 1'b1; i++) tick();
        model_vec(32'd0, mst, mv);
        chk("s1_vec_seed0", test_vec, mv);
        chk("s1_first_idx", fault_idx, 1);
        for (int i = 0; i < 5000 && done !== 1'b1; i++) tick();
        chk("s1_done", done, 1);
        chk("s1_total", total_cnt, 20);
        chk("s1_kept", kept_cnt, 0);
        chk("s1_cov", coverage, 0);
        chk("s1_no_keep_valid", kv_cyc - base_kv, 0);
        tick(); tick(); tick();
        chk("s1_done_sticky", {done, busy}, 2'b10);

        // Scenario 2: every fault detected on the first vector.
        mode = 1;
        seed = 32'h1234_5678; start = 1'b1; tick(); start = 1'b0;
        chk("s2_done_cleared", done, 0);
        for (int i = 0; i < 2000 && done !== 1'b1; i++) tick();
        chk("s2_done", done, 1);
        chk("s2_cov", coverage, 100);
        chk("s2_kept", kept_cnt, 1);
        chk("s2_total", total_cnt, 1);

        // Scenarios 3/4: faults 1..4 only, sink stalls 50 cycles.
        mode = 2; keep_ready = 1'b0;
        base_en = en_cyc; base_late = late_inj;
        seed = 32'hCAFE_F00D; start = 1'b1; tick(); start = 1'b0;
        for (int i = 0; i < 1000 && keep_valid !== 1'b1; i++) tick();
        model_vec(32'hCAFE_F00D, mst, mv);
        chk("s3_keep_valid", keep_valid, 1);
        chk("s3_kept_vec", test_vec, mv);
        chk("s3_cov", coverage, 10);
        chk("s3_exp_cnt", dut.exp_cnt_r, 1);
        cap = test_vec; bad = 0;
        for (int i = 0; i < 50; i++) begin
            tick();
            if (keep_valid !== 1'b1 || test_vec !== cap) bad++;
        end
        chk("s4_stall_stable", bad, 0);
        keep_ready = 1'b1;
        tick();
        chk("s4_accept", keep_valid, 0);
        for (int i = 0; i < 5000 && done !== 1'b1; i++) tick();
        chk("s3_done", done, 1);
        chk("s3_total", total_cnt, 21);
        chk("s3_kept", kept_cnt, 1);
        chk("s3_cov_final", coverage, 10);
        chk("s3_en_cycles", en_cyc - base_en, EXP_EN_CYC);
        chk("s3_late_inject", late_inj - base_late, EXP_LATE);

        // Scenario 5: reset during INJECT of fault 5, then reproduce.
        mode = 0;
        seed = 32'h0BAD_BEEF; start = 1'b1; tick(); start = 1'b0;
        for (int i = 0; i < 100 && !(fault_en === 1'b1 && fault_idx === 6'd5); i++) tick();
        chk("s5_at_fault5", {fault_en, fault_idx}, {1'b1, 6'd5});
        vec_a = test_vec;
        rst = 1'b1;
        tick();
        chk("s5_abort", {fault_en, busy, keep_valid}, 0);
        chk("s5_abort_cnt", {total_cnt, kept_cnt, coverage}, 0);
        rst = 1'b0;
        tick();
        start = 1'b1; tick(); start = 1'b0;
        for (int i = 0; i < 50 && fault_en !== 1'b1; i++) tick();
        model_vec(32'h0BAD_BEEF, mst, mv);
        chk("s5_repro", test_vec, vec_a);
        chk("s5_model_v1", test_vec, mv);
        for (int i = 0; i < 400 && !(fault_en === 1'b1 && total_cnt === 16'd2); i++) tick();
        model_vec(mst, mst2, mv2);
        chk("s5_model_v2", test_vec, mv2);
        rst = 1'b1; tick(); rst = 1'b0;

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
